counter_timer_ctrl: RTL and testbench
=====================================

# counter_timer_ctrl

Programmable timer controller that sequences a loadable N-bit down-counter to produce periodic or one-shot terminal-count events. A requester starts the timer with a period and a mode, and the block reports `busy`, a per-period `tick` and a one-shot `done`. It sits between control logic (sequencers, blink/debounce generators) and the counter datapath, owning load, decrement, hold and reload decisions.

## Interface
- `CNT_WIDTH`, default 8: counter and period width in bits.

- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled each cycle; requests a (re)start with `period` and `auto_reload`.
- `stop`  in  1  sampled each cycle; aborts a running timer.
- `hold`  in  1  level; freezes the count while in RUN.
- `auto_reload`  in  1  sampled with `start`; 1 = periodic, 0 = one-shot.
- `period`  in  CNT_WIDTH  sampled with `start`; cycles per tick, 1..2^CNT_WIDTH-1.
- `busy`  out  1  high while in RUN.
- `tick`  out  1  one-cycle pulse at each terminal count.
- `done`  out  1  one-cycle pulse when a one-shot run completes.
- `count`  out  CNT_WIDTH  current remaining count.

## Operation
- States: IDLE and RUN. Encoding: IDLE=0, RUN=1.
- Reset, evaluated at any state: state=IDLE. Reset values: `count`=0, `busy`=0, `tick`=0, `done`=0, `period_q`=0, `reload_q`=0. A reset mid-run aborts the run with no `tick` or `done`.
- IDLE, `start`=1, `period`≠0: latch `period_q`=`period` and `reload_q`=`auto_reload`. Then `count`=`period` and the block goes to RUN.
- IDLE, `start`=1, `period`=0: ignore the request. The block stays in IDLE and no output changes.
- Priority in RUN, highest first: `stop`, `start`, `hold`, terminal count, decrement.
  - `stop`=1: go to IDLE with `count`=0. No `tick` or `done`. `stop` also wins over a simultaneous `start`.
  - `start`=1 with `period`≠0: restart. Relatch `period_q` and `reload_q`, and set `count`=`period`. No `tick` on this cycle, even if `count` was 1.
  - `start`=1 with `period`=0 in RUN: ignore the restart and continue the current run.
  - `hold`=1: `count` is unchanged. No `tick` or `done`; a terminal count is deferred until `hold` falls.
  - `count`=1 with `reload_q`=1: `tick`=1 and `count`=`period_q`. The block stays in RUN.
  - `count`=1 with `reload_q`=0: `tick`=1, `done`=1 and `count`=0. The block goes to IDLE.
  - Otherwise: `count`=`count`-1.
- `stop` and `hold` in IDLE have no effect.
- Arithmetic: unsigned, CNT_WIDTH bits. `count` never wraps, because 0 is only reached on the transition to IDLE.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- `start` is sampled at edge k. After edge k: `busy`=1 and `count`=P.
- Periodic mode: `tick` is high for the single cycle after edges k+P, k+2P, and so on. The tick period is exactly P cycles, and P=1 gives `tick` every cycle.
- One-shot mode: `tick` and `done` are high together for the cycle after edge k+P. `busy` is 0 from that same edge onward.
- Each held cycle extends the current period by exactly one cycle.
- Back-to-back runs: `start` may be asserted in the cycle where `done` is high. The new run then begins at the next edge with no idle gap.

## Structure
- Package `counter_ctrl_pkg` holds:
  - the state encoding constants `ST_IDLE` and `ST_RUN`;
  - the default width constant.
- Sub-module `down_counter`, parameter CNT_WIDTH, ports:
  - `clk`, `reset`, `load`, `load_val`, `dec`, `value`;
  - synchronous load has priority over `dec`.
- The controller contains the FSM, the `period_q`/`reload_q` latches and the output pulse registers, and drives `load`/`dec`.

## Test plan
- Reset, then periodic run (CNT_WIDTH=3, P=5, `auto_reload`=1) -> `tick` pulses every 5 cycles, `count` sequence 5,4,3,2,1,5…, `busy` stays 1.
- One-shot run (P=3, `auto_reload`=0) -> after 3 cycles `tick`=`done`=1 for one cycle, then `busy`=0 and `count`=0.
- Periodic P=4, `hold` high 2 cycles while `count`=2 -> `count` holds at 2, and that tick is delayed by exactly 2 cycles.
- `start` and `stop` together in RUN at `count`=3 -> IDLE next cycle, `count`=0, no `tick`. In IDLE, `start` with P=0 -> stays IDLE, `busy`=0.
- Restart in RUN at `count`=1 with P=7 -> `count`=7, no `tick` that cycle. `reset` asserted mid-run -> all outputs 0 next cycle, no `done`.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter timer controller.
package counter_ctrl_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/counter_timer_ctrl_down_counter.sv
// Loadable down-counter datapath; synchronous load wins over decrement.
module down_counter #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= value - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Timer controller: sequences a down-counter for periodic or one-shot terminal-count events.
module counter_timer_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  input  logic                 auto_reload,
  input  logic [CNT_WIDTH-1:0] period,
  output logic                 busy,
  output logic                 tick,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count
);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   reload_q, reload_d;
  logic                   tick_d, done_d;
  logic                   load, dec;
  logic [CNT_WIDTH-1:0]   load_val;
  logic                   start_ok;

  assign start_ok = start && (period != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      reload_q <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      reload_q <= reload_d;
      tick     <= tick_d;
      done     <= done_d;
    end
  end

  // busy is a direct decode of the state flop, so it is still registered
  assign busy = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = '0;
    dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          period_d = period;
          reload_d = auto_reload;
          load     = 1'b1;
          load_val = period;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          load     = 1'b1;
          load_val = '0;
          state_d  = ST_IDLE;
        end else if (start_ok) begin
          period_d = period;
          reload_d = auto_reload;
          load     = 1'b1;
          load_val = period;
        end else if (hold) begin
          // count frozen; a pending terminal count waits for hold to drop
        end else if (count == CNT_WIDTH'(1)) begin
          tick_d = 1'b1;
          load   = 1'b1;
          if (reload_q) begin
            load_val = period_q;
          end else begin
            load_val = '0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  down_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_down_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .value    (count)
  );

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Table-driven directed bench for counter_timer_ctrl at CNT_WIDTH=3.
module tb_counter_timer_ctrl;

  localparam int unsigned W = 3;

  typedef struct {
    logic         start;
    logic         stop;
    logic         hold;
    logic         ar;
    logic [W-1:0] period;
    logic         busy;
    logic         tick;
    logic         done;
    logic [W-1:0] count;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         hold;
  logic         auto_reload;
  logic [W-1:0] period;
  logic         busy;
  logic         tick;
  logic         done;
  logic [W-1:0] count;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  counter_timer_ctrl #(.CNT_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
    .auto_reload (auto_reload),
    .period      (period),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eb, input logic et,
                           input logic ed, input logic [W-1:0] ec);
    check({tag, ".busy"},  int'(busy),  int'(eb));
    check({tag, ".tick"},  int'(tick),  int'(et));
    check({tag, ".done"},  int'(done),  int'(ed));
    check({tag, ".count"}, int'(count), int'(ec));
  endtask

  task automatic add(input int s, input int sp, input int h, input int ar, input int p,
                     input int eb, input int et, input int ed, input int ec);
    vec_t v;
    v.start  = 1'(s);
    v.stop   = 1'(sp);
    v.hold   = 1'(h);
    v.ar     = 1'(ar);
    v.period = W'(p);
    v.busy   = 1'(eb);
    v.tick   = 1'(et);
    v.done   = 1'(ed);
    v.count  = W'(ec);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic sp, input logic h, input logic ar,
                       input logic [W-1:0] p);
    @(negedge clk);
    start = s; stop = sp; hold = h; auto_reload = ar; period = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    auto_reload = 1'b0; period = '0;

    //   st sp h ar  P   busy tick done count
    // periodic P=5
    add(1, 0, 0, 1, 5,  1, 0, 0, 5);
    add(0, 0, 0, 0, 0,  1, 0, 0, 4);
    add(0, 0, 0, 0, 0,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 5);
    add(0, 0, 0, 0, 0,  1, 0, 0, 4);
    add(0, 0, 0, 0, 0,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 5);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // one-shot P=3
    add(1, 0, 0, 0, 3,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0);
    // one-shot P=1 then back-to-back periodic P=2
    add(1, 0, 0, 0, 1,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0);
    add(1, 0, 0, 1, 2,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);
    // periodic P=4 with two held cycles at count=2
    add(1, 0, 0, 1, 4,  1, 0, 0, 4);
    add(0, 0, 0, 0, 0,  1, 0, 0, 3);
    add(0, 0, 0, 0, 0,  1, 0, 0, 2);
    add(0, 0, 1, 0, 0,  1, 0, 0, 2);
    add(0, 0, 1, 0, 0,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 4);
    add(0, 0, 0, 0, 0,  1, 0, 0, 3);
    // start+stop together at count=3
    add(1, 1, 0, 1, 6,  0, 0, 0, 0);
    // IDLE: P=0 start ignored, stop/hold no effect
    add(1, 0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 1, 1, 0, 0,  0, 0, 0, 0);
    // restart at count=1 with P=7
    add(1, 0, 0, 1, 2,  1, 0, 0, 2);
    add(0, 0, 0, 0, 0,  1, 0, 0, 1);
    add(1, 0, 0, 1, 7,  1, 0, 0, 7);
    add(0, 0, 0, 0, 0,  1, 0, 0, 6);
    add(1, 0, 0, 0, 0,  1, 0, 0, 5);
    add(1, 0, 1, 0, 0,  1, 0, 0, 5);
    // periodic P=1 ticks every cycle
    add(1, 0, 0, 1, 1,  1, 0, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 1, 0, 1);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, W'(0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].ar, vecs[i].period);
      check_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].tick,
                vecs[i].done, vecs[i].count);
    end

    // reset mid one-shot run: outputs clear and no done ever follows
    drive(1'b1, 1'b0, 1'b0, 1'b0, W'(4));
    check_all("mr_start", 1'b1, 1'b0, 1'b0, W'(4));
    drive(1'b0, 1'b0, 1'b0, 1'b0, W'(0));
    check_all("mr_run", 1'b1, 1'b0, 1'b0, W'(3));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("mr_reset", 1'b0, 1'b0, 1'b0, W'(0));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, W'(0));
      check_all($sformatf("mr_after%0d", c), 1'b0, 1'b0, 1'b0, W'(0));
    end

    // hold across terminal count defers the one-shot tick/done
    drive(1'b1, 1'b0, 1'b0, 1'b0, W'(2));
    check_all("hd_start", 1'b1, 1'b0, 1'b0, W'(2));
    drive(1'b0, 1'b0, 1'b0, 1'b0, W'(0));
    check_all("hd_c1", 1'b1, 1'b0, 1'b0, W'(1));
    drive(1'b0, 1'b0, 1'b1, 1'b0, W'(0));
    check_all("hd_hold", 1'b1, 1'b0, 1'b0, W'(1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, W'(0));
    check_all("hd_done", 1'b0, 1'b1, 1'b1, W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
